ibr128_block_packer: RTL

Upstream feeder for the IBR128 block-cipher operation-mode stage. Accepts a 32-bit word stream with valid/ready handshake and assembles 128-bit plaintext blocks. Applies PKCS#7 padding to the final block of each message and marks the first block of each message for IV load. Holds up to two finished blocks in a buffer so the word stream keeps flowing while the cipher stage is busy.

---
 rtl/ibr128_block_packer_if.sv | 23 ++
 rtl/ibr128_block_packer.sv | 108 ++++++++++
 2 files changed

// File: rtl/ibr128_block_packer_if.sv
// ibr128_block_packer_if: word-stream input and block-stream output of the block packer
interface ibr128_block_packer_if;
    logic [31:0]  word_data;
    logic         word_valid;
    logic         word_last;
    logic [2:0]   word_bytes;
    logic         word_ready;
    logic [127:0] plain_text;
    logic         fb;
    logic         block_last;
    logic         block_valid;
    logic         block_accept;

    modport master (
        output word_data, word_valid, word_last, word_bytes, block_accept,
        input  word_ready, plain_text, fb, block_last, block_valid
    );

    modport slave (
        input  word_data, word_valid, word_last, word_bytes, block_accept,
        output word_ready, plain_text, fb, block_last, block_valid
    );
endinterface

// File: rtl/ibr128_block_packer.sv
// ibr128_block_packer: packs 32-bit words into 128-bit blocks with PKCS#7 or zero padding behind a 2-entry buffer
module ibr128_block_packer #(
    parameter bit PAD_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    ibr128_block_packer_if.slave bus,
    output logic [15:0]          block_count
);
    typedef enum logic {FILL, PAD} state_t;

    state_t       state, state_n;
    logic [1:0]   wi, wi_n;
    logic         fb_pend, fb_pend_n;
    logic [127:0] acc, filled, padded, push_data;
    logic [129:0] mem [2];
    logic         rd_ptr, wr_ptr;
    logic [1:0]   count;
    logic         pop, space, take, push, push_fb, push_last;
    logic [2:0]   nb;
    logic [4:0]   d;
    logic [7:0]   pad_byte;

    assign pop             = (count != 2'd0) && bus.block_accept;
    assign space           = (count != 2'd2) || pop;
    assign bus.word_ready  = !rst && enable && state == FILL && space;
    assign take            = bus.word_valid && bus.word_ready;
    assign nb              = (bus.word_bytes == 3'd0 || bus.word_bytes > 3'd4) ? 3'd4 : bus.word_bytes;
    assign d               = {1'b0, wi, 2'b00} + {2'b00, nb};
    assign pad_byte        = PAD_EN ? 8'd16 - {3'b000, d} : 8'h00;
    assign bus.block_valid = count != 2'd0;
    assign bus.plain_text  = bus.block_valid ? mem[rd_ptr][129:2] : '0;
    assign bus.fb          = bus.block_valid && mem[rd_ptr][1];
    assign bus.block_last  = bus.block_valid && mem[rd_ptr][0];

    // Drop the incoming word into its slot and overwrite the tail of a final block with pad bytes
    always_comb begin
        filled = acc;
        for (int i = 0; i < 4; i++)
            filled[127-32*i -: 32] = (2'(i) == wi) ? bus.word_data : acc[127-32*i -: 32];
        padded = filled;
        for (int k = 0; k < 16; k++)
            padded[127-8*k -: 8] = (bus.word_last && 5'(k) >= d) ? pad_byte : filled[127-8*k -: 8];
    end

    // Next state: word slot, first-block flag, FSM state and what gets pushed into the buffer
    always_comb begin
        state_n   = state;
        wi_n      = wi;
        fb_pend_n = fb_pend;
        push      = 1'b0;
        push_fb   = fb_pend;
        push_last = 1'b0;
        push_data = padded;
        if (state == PAD) begin
            push_data = {16{8'h10}};
            push_fb   = 1'b0;
            push_last = 1'b1;
            if (space) begin
                push      = 1'b1;
                fb_pend_n = 1'b1;
                state_n   = FILL;
            end
        end else if (take) begin
            wi_n = wi + 2'd1;
            if (bus.word_last) begin
                push      = 1'b1;
                wi_n      = 2'd0;
                push_last = !(PAD_EN && d == 5'd16);
                fb_pend_n = push_last;
                state_n   = push_last ? FILL : PAD;
            end else if (wi == 2'd3) begin
                push      = 1'b1;
                fb_pend_n = 1'b0;
            end
        end
    end

    // Control registers; enable low flushes the buffer, the partial block and the block counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            wi          <= 2'd0;
            fb_pend     <= 1'b1;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            block_count <= 16'd0;
        end else begin
            state       <= enable ? state_n : FILL;
            wi          <= enable ? wi_n : 2'd0;
            fb_pend     <= !enable || fb_pend_n;
            rd_ptr      <= enable && (rd_ptr ^ pop);
            wr_ptr      <= enable && (wr_ptr ^ push);
            count       <= enable ? count + 2'(push) - 2'(pop) : 2'd0;
            block_count <= enable ? block_count + 16'(push) : 16'd0;
        end
    end

    // Datapath storage needs no reset: empty slots are masked at the outputs
    always_ff @(posedge clk) begin
        if (take)
            acc <= filled;
        if (push)
            mem[wr_ptr] <= {push_data, push_fb, push_last};
    end
endmodule
